activation_pla: RTL and testbench

- Parametrised successor to the single-mode sigmoid unit: a fixed-point, multi-mode activation block for the neural-net datapath.
- Latches a vector of N signed fixed-point elements on a start pulse and processes LANES elements per cycle through shared lanes.
- Each lane applies one selected activation: piecewise-linear sigmoid, ReLU, sigmoid derivative or passthrough.
- Writes the results into a held output vector and pulses done when the vector is complete; it sits between a layer's accumulator output and the next layer's input.

---
 rtl/activation_pla.sv | 138 +++++++++++++
 tb/tb_activation_pla.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/activation_pla.sv
// Multi-mode fixed-point activation unit: latches an N-element vector on start
// and applies sigmoid / ReLU / sigmoid-derivative / passthrough, LANES elements per cycle.
module activation_pla #(
  parameter int W     = 16,
  parameter int F     = 11,
  parameter int N     = 2,
  parameter int LANES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W*N-1:0] x,
  input  logic           start,
  input  logic [1:0]     mode,
  output logic [W*N-1:0] y,
  output logic           done,
  output logic           busy
);

  localparam int K  = N / LANES;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  // Breakpoints and offsets of the piecewise-linear sigmoid, all in Q.F
  localparam logic [W-1:0] C_ONE  = W'(32'd1) << F;
  localparam logic [W-1:0] C_FIVE = W'(32'd5) << F;
  localparam logic [W-1:0] C_B2   = W'(32'd19) << (F - 3);
  localparam logic [W-1:0] C_O2   = W'(32'd27) << (F - 5);
  localparam logic [W-1:0] C_O1   = W'(32'd5) << (F - 3);
  localparam logic [W-1:0] C_O0   = W'(32'd1) << (F - 1);
  localparam logic [W-1:0] C_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] C_MIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W*N-1:0]   r_x;
  logic [1:0]       r_mode;
  logic [CW-1:0]    r_cnt;
  logic [W*N-1:0]   r_y;
  logic             r_done;
  logic             r_busy;
  logic             w_load;
  logic             w_write;
  logic             w_last;
  logic             w_done_nxt;
  logic             w_busy_nxt;
  logic [W-1:0]     w_lane_y [LANES];

  function automatic logic [W-1:0] f_sigmoid(input logic [W-1:0] v);
    logic [W-1:0] a;
    logic [W-1:0] s;
    if (v == C_MIN) a = C_MAX;
    else if (v[W-1]) a = -v;
    else a = v;
    if (a >= C_FIVE) s = C_ONE;
    else if (a >= C_B2) s = (a >> 3'd5) + C_O2;
    else if (a >= C_ONE) s = (a >> 3'd3) + C_O1;
    else s = (a >> 3'd2) + C_O0;
    return v[W-1] ? (C_ONE - s) : s;
  endfunction

  function automatic logic [W-1:0] f_act(input logic [W-1:0] v, input logic [1:0] m);
    logic [W-1:0]   s;
    logic [2*W-1:0] p;
    s = f_sigmoid(v);
    p = {{W{1'b0}}, s} * {{W{1'b0}}, C_ONE - s};
    case (m)
      2'b00:   return s;
      2'b01:   return v[W-1] ? {W{1'b0}} : v;
      2'b10:   return p[F +: W];
      2'b11:   return v;
      default: return v;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_last      = (r_cnt == CW'(K - 1));
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control and next-output decode
  always_comb begin
    w_load     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_write    = (r_state == S_RUN);
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Per-lane activation of the current group
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_y[l] = f_act(r_x[W*(int'(r_cnt)*LANES + l) +: W], r_mode);
    end
  end

  // Datapath: operand latch, group counter, result vector and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_mode <= 2'b00;
      r_cnt  <= '0;
      r_y    <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      if (w_load) begin
        r_x    <= x;
        r_mode <= mode;
        r_cnt  <= '0;
      end else if (w_write) begin
        r_cnt  <= r_cnt + CW'(1);
      end
      for (int l = 0; l < LANES; l++) begin
        if (w_write) r_y[W*(int'(r_cnt)*LANES + l) +: W] <= w_lane_y[l];
      end
      r_done <= w_done_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign y    = r_y;
  assign done = r_done;
  assign busy = r_busy;

endmodule

// File: tb/tb_activation_pla.sv
// Self-checking bench for activation_pla: directed plan vectors plus random runs
// against a behavioural model, on a 2x1-lane and a 4x2-lane instance.
module tb_activation_pla;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] x2 = 32'd0;
  logic        start2 = 1'b0;
  logic [1:0]  mode2 = 2'b00;
  logic [31:0] y2;
  logic        done2, busy2;
  logic [63:0] x4 = 64'd0;
  logic        start4 = 1'b0;
  logic [1:0]  mode4 = 2'b00;
  logic [63:0] y4;
  logic        done4, busy4;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  activation_pla #(.W(16), .F(11), .N(2), .LANES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x2), .start(start2), .mode(mode2),
    .y(y2), .done(done2), .busy(busy2));

  activation_pla #(.W(16), .F(11), .N(4), .LANES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .start(start4), .mode(mode4),
    .y(y4), .done(done4), .busy(busy4));

  // Reference model straight from the activation rules, in integer arithmetic (Q4.11)
  function automatic logic [15:0] ref_act(input logic [15:0] xv, input logic [1:0] m);
    int v, a, s;
    v = int'($signed(xv));
    a = (v < 0) ? -v : v;
    if (a > 32767) a = 32767;
    if (a >= 5 * 2048) s = 2048;
    else if (a >= 4864) s = a / 32 + 1728;
    else if (a >= 2048) s = a / 8 + 1280;
    else s = a / 4 + 1024;
    if (v < 0) s = 2048 - s;
    case (m)
      2'b00:   return 16'(s);
      2'b01:   return (v < 0) ? 16'd0 : xv;
      2'b10:   return 16'((s * (2048 - s)) / 2048);
      default: return xv;
    endcase
  endfunction

  function automatic logic [31:0] ref_vec2(input logic [31:0] xv, input logic [1:0] m);
    return {ref_act(xv[31:16], m), ref_act(xv[15:0], m)};
  endfunction

  function automatic logic [63:0] ref_vec4(input logic [63:0] xv, input logic [1:0] m);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = ref_act(xv[16*i +: 16], m);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full run on the 2-element instance with cycle-exact handshake checks
  task automatic run2(input logic [31:0] xv, input logic [1:0] m, input logic [31:0] exp_y, input string nm);
    x2 = xv; mode2 = m; start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (busy2 !== 1'b1 || done2 !== 1'b0) begin
        errors++; $display("FAIL %s busy/done c%0d: busy=%b done=%b required busy=1 done=0", nm, c, busy2, done2);
      end
      step();
    end
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || y2 !== exp_y) begin
      errors++; $display("FAIL %s result: y=%h done=%b busy=%b required y=%h done=1 busy=0", nm, y2, done2, busy2, exp_y);
    end
  endtask

  task automatic run4(input logic [63:0] xv, input logic [1:0] m, input logic [63:0] exp_y, input string nm);
    x4 = xv; mode4 = m; start4 = 1'b1;
    step();
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      errors++; $display("FAIL %s busy4: busy=%b done=%b required busy=1 done=0", nm, busy4, done4);
    end
    step();
    checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      errors++; $display("FAIL %s busy4 c2: busy=%b done=%b required busy=1 done=0", nm, busy4, done4);
    end
    step();
    checks++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || y4 !== exp_y) begin
      errors++; $display("FAIL %s result4: y=%h done=%b required y=%h done=1", nm, y4, done4, exp_y);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (y2 !== 32'd0 || done2 !== 1'b0 || busy2 !== 1'b0 || y4 !== 64'd0 || done4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL reset_state: y2=%h d=%b b=%b y4=%h d=%b b=%b required all 0", y2, done2, busy2, y4, done4, busy4);
    end
  endtask

  task automatic test_sigmoid();
    run2({16'hF800, 16'h0800}, 2'b00, {16'h0200, 16'h0600}, "sig_pm1");
    step();
    checks++;
    if (done2 !== 1'b0) begin
      errors++; $display("FAIL done_width: done=%b required 0", done2);
    end
    run4({16'h0000, 16'h2800, 16'h1800, 16'hE800}, 2'b00, {16'h0400, 16'h0800, 16'h0780, 16'h0080}, "sig_seg");
    step();
    run2({16'h8000, 16'h1300}, 2'b00, {16'h0000, 16'h0758}, "sig_bound");
    step();
  endtask

  task automatic test_modes();
    run2({16'h1800, 16'hE800}, 2'b01, {16'h1800, 16'h0000}, "relu");
    step();
    run2({16'h1800, 16'hE800}, 2'b11, {16'h1800, 16'hE800}, "pass");
    step();
    run2({16'h0800, 16'h0000}, 2'b10, {16'h0180, 16'h0200}, "deriv");
    step();
  endtask

  task automatic test_handshake();
    // start pulsed during RUN must not disturb the latched operands
    x2 = {16'h0800, 16'hF800}; mode2 = 2'b00; start2 = 1'b1;
    step();
    x2 = {16'h2800, 16'h2800}; mode2 = 2'b11;
    step();
    start2 = 1'b0;
    step();
    checks++;
    if (done2 !== 1'b1 || y2 !== {16'h0600, 16'h0200}) begin
      errors++; $display("FAIL start_in_run: y=%h done=%b required y=06000200 done=1", y2, done2);
    end
    // start during the done cycle begins a new run immediately
    run2({16'hE800, 16'h1800}, 2'b01, {16'h0000, 16'h1800}, "b2b");
    run4({16'h1800, 16'hF800, 16'h7FFF, 16'h0100}, 2'b00, ref_vec4({16'h1800, 16'hF800, 16'h7FFF, 16'h0100}, 2'b00), "b2b4a");
    run4({16'h0000, 16'h0800, 16'hF000, 16'h8000}, 2'b10, ref_vec4({16'h0000, 16'h0800, 16'hF000, 16'h8000}, 2'b10), "b2b4b");
    step();
  endtask

  task automatic test_async_reset();
    logic seen_done;
    x2 = {16'h1800, 16'h0800}; mode2 = 2'b11; start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y2 !== 32'd0 || done2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL async_reset: y=%h done=%b busy=%b required 0 0 0", y2, done2, busy2);
    end
    step();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (done2 === 1'b1 || busy2 === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL no_done_after_reset: activity=%b required 0", seen_done);
    end
    run2({16'hE800, 16'h1800}, 2'b00, {16'h0080, 16'h0780}, "post_reset");
    step();
  endtask

  task automatic test_hold();
    logic [31:0] held;
    held = y2;
    for (int c = 0; c < 10; c++) begin
      x2 = $urandom; mode2 = 2'($urandom_range(0, 3));
      step();
      checks++;
      if (y2 !== held || done2 !== 1'b0 || busy2 !== 1'b0) begin
        errors++; $display("FAIL hold c%0d: y=%h done=%b busy=%b required y=%h 0 0", c, y2, done2, busy2, held);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r2;
    logic [63:0] r4;
    logic [1:0]  m;
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom_range(0, 3));
      r2 = $urandom;
      if (i % 6 == 0) r2[15:0] = 16'h8000;
      run2(r2, m, ref_vec2(r2, m), "rand2");
      step();
      r4 = {$urandom, $urandom};
      run4(r4, m, ref_vec4(r4, m), "rand4");
      step();
    end
  endtask

  initial begin
    #1 test_reset();
    #12 rst_n = 1'b1;
    step();
    test_sigmoid();
    test_modes();
    test_handshake();
    test_async_reset();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
